// File: rtl/mac_fp_mult_pipe.sv
// mac_fp_mult_pipe: three-stage pipelined floating-point multiplier for the
// MAC datapath. Subnormal inputs and outputs are flushed to zero, and rounding
// is either round-to-nearest-even or truncation. A single global enable moves
// the whole pipeline forward. It is held only while an unconsumed result
// blocks the output.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand pair a_i/b_i valid
//   in_ready_o   pipeline accepts operands this cycle
//   a_i, b_i     operands, packed {sign, exp, mant}
//   out_valid_o  out_result_o/out_flags_o valid
//   out_ready_i  downstream accepts the result
//   out_result_o packed product
//   out_flags_o  {invalid, overflow, underflow, inexact}
module mac_fp_mult_pipe #(
   parameter int EXP_W     = 8,
   parameter int MANT_W    = 23,
   parameter int ROUND_RNE = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [EXP_W+MANT_W:0] a_i,
   input  logic [EXP_W+MANT_W:0] b_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [EXP_W+MANT_W:0] out_result_o,
   output logic [3:0]            out_flags_o
);

   localparam int W  = EXP_W + MANT_W + 1;
   localparam int PW = 2 * MANT_W + 2;
   localparam int SW = EXP_W + 3;   // signed working width for the result exponent
   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
   localparam logic [SW-1:0]    BIAS_SW  = SW'((2 ** (EXP_W - 1)) - 1);
   localparam logic [SW-1:0]    EMAX_SW  = SW'((2 ** EXP_W) - 1);
   localparam logic             RNE_EN   = (ROUND_RNE != 0);

   // Operand-pair class carried alongside the data
   localparam logic [1:0] CLS_NORM = 2'd0;
   localparam logic [1:0] CLS_ZERO = 2'd1;
   localparam logic [1:0] CLS_INF  = 2'd2;
   localparam logic [1:0] CLS_NAN  = 2'd3;

   logic              advance_s;
   logic [EXP_W-1:0]  ea_s, eb_s;
   logic [MANT_W-1:0] fa_s, fb_s;
   logic              a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;

   logic              v1_d, v1_q, v2_q, v3_q;
   logic              sign1_d, sign1_q, sign2_q;
   logic [1:0]        cls1_d, cls1_q, cls2_q;
   logic [EXP_W+1:0]  esum1_d, esum1_q, esum2_q;
   logic [MANT_W:0]   ma1_d, mb1_d, ma1_q, mb1_q;
   logic [PW-1:0]     prod2_d, prod2_q;

   logic              norm_s, guard_s, sticky_s, round_up_s, carry_s, ovf_s, unf_s;
   logic [PW-2:0]     nprod_s;
   logic [MANT_W-1:0] frac_s, frac_r_s;
   logic [MANT_W+1:0] sig_r_s;
   logic [SW-1:0]     e_s;
   logic [W-1:0]      res_d, res_q;
   logic [3:0]        flags_d, flags_q;

   // The pipeline moves whenever the output slot is empty or being drained
   assign advance_s    = out_ready_i | ~v3_q;
   assign in_ready_o   = advance_s;
   assign out_valid_o  = v3_q;
   assign out_result_o = res_q;
   assign out_flags_o  = flags_q;

   // Stage 1: unpack and classify. A zero exponent is zero whatever the mantissa
   assign ea_s     = a_i[W-2:MANT_W];
   assign eb_s     = b_i[W-2:MANT_W];
   assign fa_s     = a_i[MANT_W-1:0];
   assign fb_s     = b_i[MANT_W-1:0];
   assign a_zero_s = (ea_s == EXP_ZERO);
   assign b_zero_s = (eb_s == EXP_ZERO);
   assign a_inf_s  = (ea_s == EXP_ONES) & (fa_s == {MANT_W{1'b0}});
   assign b_inf_s  = (eb_s == EXP_ONES) & (fb_s == {MANT_W{1'b0}});
   assign a_nan_s  = (ea_s == EXP_ONES) & (fa_s != {MANT_W{1'b0}});
   assign b_nan_s  = (eb_s == EXP_ONES) & (fb_s != {MANT_W{1'b0}});

   assign v1_d    = in_valid_i;
   assign sign1_d = a_i[W-1] ^ b_i[W-1];
   assign esum1_d = {2'b00, ea_s} + {2'b00, eb_s};
   assign ma1_d   = {1'b1, fa_s};
   assign mb1_d   = {1'b1, fb_s};

   // Collapse both operand classes into one class in result-priority order
   always_comb begin
      cls1_d = CLS_NORM;
      if (a_nan_s | b_nan_s | (a_inf_s & b_zero_s) | (b_inf_s & a_zero_s)) begin
         cls1_d = CLS_NAN;
      end else if (a_inf_s | b_inf_s) begin
         cls1_d = CLS_INF;
      end else if (a_zero_s | b_zero_s) begin
         cls1_d = CLS_ZERO;
      end else begin
         cls1_d = CLS_NORM;
      end
   end

   // Stage 2: full-width significand product
   assign prod2_d = PW'(ma1_q) * PW'(mb1_q);

   // Stage 3: normalise so the leading one sits just above the fraction, then round
   always_comb begin
      norm_s     = prod2_q[PW-1];
      nprod_s    = norm_s ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
      frac_s     = nprod_s[PW-2:MANT_W+1];
      guard_s    = nprod_s[MANT_W];
      sticky_s   = |nprod_s[MANT_W-1:0];
      round_up_s = RNE_EN & guard_s & (sticky_s | frac_s[0]);
      sig_r_s    = {2'b01, frac_s} + {{(MANT_W+1){1'b0}}, round_up_s};
      // A carry out of rounding leaves 10...0, so the fraction becomes all zero
      carry_s    = sig_r_s[MANT_W+1];
      frac_r_s   = carry_s ? sig_r_s[MANT_W:1] : sig_r_s[MANT_W-1:0];
      e_s        = {1'b0, esum2_q} - BIAS_SW + {{(SW-1){1'b0}}, norm_s}
                   + {{(SW-1){1'b0}}, carry_s};
      ovf_s      = ~e_s[SW-1] & (e_s >= EMAX_SW);
      unf_s      = e_s[SW-1] | (e_s == {SW{1'b0}});
   end

   // Result selection: specials first, then overflow, flush-to-zero, normal
   always_comb begin
      res_d   = {W{1'b0}};
      flags_d = 4'b0000;
      case (cls2_q)
         CLS_NAN: begin
            res_d   = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
            flags_d = 4'b1000;
         end
         CLS_INF: begin
            res_d   = {sign2_q, EXP_ONES, {MANT_W{1'b0}}};
            flags_d = 4'b0000;
         end
         CLS_ZERO: begin
            res_d   = {sign2_q, EXP_ZERO, {MANT_W{1'b0}}};
            flags_d = 4'b0000;
         end
         CLS_NORM: begin
            if (ovf_s) begin
               // Truncation never rounds up to infinity, so it saturates instead
               res_d   = RNE_EN ? {sign2_q, EXP_ONES, {MANT_W{1'b0}}}
                                : {sign2_q, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
               flags_d = 4'b0101;
            end else if (unf_s) begin
               res_d   = {sign2_q, EXP_ZERO, {MANT_W{1'b0}}};
               flags_d = 4'b0011;
            end else begin
               res_d   = {sign2_q, e_s[EXP_W-1:0], frac_r_s};
               flags_d = {3'b000, guard_s | sticky_s};
            end
         end
         default: begin
            res_d   = {W{1'b0}};
            flags_d = 4'b0000;
         end
      endcase
   end

   // Pipeline registers: all stages load together on advance, else hold
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         cls1_q  <= CLS_ZERO;
         cls2_q  <= CLS_ZERO;
         esum1_q <= {(EXP_W+2){1'b0}};
         esum2_q <= {(EXP_W+2){1'b0}};
         ma1_q   <= {(MANT_W+1){1'b0}};
         mb1_q   <= {(MANT_W+1){1'b0}};
         prod2_q <= {PW{1'b0}};
         res_q   <= {W{1'b0}};
         flags_q <= 4'b0000;
      end else if (advance_s) begin
         v1_q    <= v1_d;
         sign1_q <= sign1_d;
         cls1_q  <= cls1_d;
         esum1_q <= esum1_d;
         ma1_q   <= ma1_d;
         mb1_q   <= mb1_d;
         v2_q    <= v1_q;
         sign2_q <= sign1_q;
         cls2_q  <= cls1_q;
         esum2_q <= esum1_q;
         prod2_q <= prod2_d;
         v3_q    <= v2_q;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_mac_fp_mult_pipe.sv
// Bench for mac_fp_mult_pipe with FP32 defaults. Two instances share the
// stimulus: one rounds to nearest-even and one truncates. Every accepted
// operand pair is scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a, b;
   logic        in_ready_n, in_ready_z, out_valid_n, out_valid_z;
   logic [31:0] res_n, res_z;
   logic [3:0]  fl_n, fl_z;

   always #5 clk = ~clk;

   mac_fp_mult_pipe #(.EXP_W(8), .MANT_W(23), .ROUND_RNE(1)) u_dut_rne (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_n),
      .a_i(a), .b_i(b), .out_valid_o(out_valid_n), .out_ready_i(out_ready),
      .out_result_o(res_n), .out_flags_o(fl_n));

   mac_fp_mult_pipe #(.EXP_W(8), .MANT_W(23), .ROUND_RNE(0)) u_dut_rtz (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_z),
      .a_i(a), .b_i(b), .out_valid_o(out_valid_z), .out_ready_i(out_ready),
      .out_result_o(res_z), .out_flags_o(fl_z));

   typedef struct packed {
      logic [31:0] rn;
      logic [3:0]  fn;
      logic [31:0] rz;
      logic [3:0]  fz;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_err = 0;
   int          n_chk = 0;
   int          acc_cnt = 0;
   logic [31:0] cyc = 32'd0;
   bit          lat_chk = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: exact integer product of the significands, then IEEE rounding
   // decided by comparing the discarded remainder with one half ulp.
   function automatic logic [35:0] fp_mul_ref(input logic [31:0] x, input logic [31:0] y, input bit rne);
      int              ex, ey, k, sh, e;
      bit              sg, xz, yz, xi, yi, xn, yn, inexact;
      longint unsigned p, q, rem, half;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      sg = x[31] ^ y[31];
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 23'd0);
      yi = (ey == 255) && (y[22:0] == 23'd0);
      xn = (ex == 255) && (x[22:0] != 23'd0);
      yn = (ey == 255) && (y[22:0] != 23'd0);
      if (xn || yn || (xi && yz) || (yi && xz)) return {4'b1000, 32'h7FC00000};
      if (xi || yi) return {4'b0000, sg, 31'h7F800000};
      if (xz || yz) return {4'b0000, sg, 31'h0};
      p    = (64'(x[22:0]) | 64'h800000) * (64'(y[22:0]) | 64'h800000);
      k    = (p >= (64'd1 << 47)) ? 47 : 46;
      sh   = k - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      inexact = (rem != 64'd0);
      if (rne && ((rem > half) || ((rem == half) && q[0]))) q = q + 64'd1;
      e = ex + ey - 127 + (k - 46);
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {4'b0101, sg, rne ? 31'h7F800000 : 31'h7F7FFFFF};
      if (e <= 0) return {4'b0011, sg, 31'h0};
      return {3'b000, inexact, sg, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] m;
      int          sel;
      sel = int'($urandom_range(0, 9));
      m   = 23'($urandom);
      case (sel)
         0: e = 8'd0;
         1: begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) m = 23'd0;
         end
         2: e = 8'($urandom_range(1, 20));
         3: e = 8'($urandom_range(230, 254));
         4: begin
            e = 8'($urandom_range(100, 150));
            m = ($urandom_range(0, 1) == 0) ? 23'h7FFFFF : 23'h000001;
         end
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {1'($urandom), e, m};
   endfunction

   always @(posedge clk) cyc <= cyc + 32'd1;

   // Scoreboard: push on input transfer, pop and compare on output transfer
   always @(negedge clk) begin
      exp_t        ent;
      logic [35:0] m;
      if (rst) begin
         sb.delete();
      end else begin
         if (sb.size() == 0) begin
            check_eq("idle_valid_rne", 64'(out_valid_n), 64'd0);
            check_eq("idle_valid_rtz", 64'(out_valid_z), 64'd0);
         end else if (out_valid_n && out_ready) begin
            ent = sb.pop_front();
            check_eq("res_rne", 64'(res_n), 64'(ent.rn));
            check_eq("flags_rne", 64'(fl_n), 64'(ent.fn));
            check_eq("valid_rtz", 64'(out_valid_z), 64'd1);
            check_eq("res_rtz", 64'(res_z), 64'(ent.rz));
            check_eq("flags_rtz", 64'(fl_z), 64'(ent.fz));
            if (lat_chk) check_eq("latency", 64'(cyc - ent.cyc), 64'd3);
         end
         if (in_valid && in_ready_n) begin
            m       = fp_mul_ref(a, b, 1'b1);
            ent.rn  = m[31:0];
            ent.fn  = m[35:32];
            m       = fp_mul_ref(a, b, 1'b0);
            ent.rz  = m[31:0];
            ent.fz  = m[35:32];
            ent.cyc = cyc;
            sb.push_back(ent);
            acc_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] x, input logic [31:0] y);
      bit done = 1'b0;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = in_ready_n;
         @(posedge clk);
         #1;
      end
      if (!done) check_eq("send_timeout", 64'(done), 64'd1);
   endtask

   task automatic run_vec(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] en, input logic [3:0] fen,
                          input logic [31:0] ez, input logic [3:0] fez);
      int k   = 0;
      bit got = 1'b0;
      send(x, y);
      in_valid = 1'b0;
      while (!got && k < 10) begin
         k++;
         @(negedge clk);
         got = out_valid_n;
      end
      check_eq("vec_seen", 64'(got), 64'd1);
      check_eq("vec_latency", 64'(k), 64'd3);
      check_eq("vec_res_rne", 64'(res_n), 64'(en));
      check_eq("vec_flags_rne", 64'(fl_n), 64'(fen));
      check_eq("vec_res_rtz", 64'(res_z), 64'(ez));
      check_eq("vec_flags_rtz", 64'(fl_z), 64'(fez));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      check_eq("drain", 64'(sb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] bp_a[5] = '{32'h3FC00000, 32'h40400000, 32'hC0000000, 32'h3F800001, 32'h7F000000};
   logic [31:0] bp_b[5] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h3F800001, 32'h7F000000};
   bit          rdone = 1'b0;

   initial begin
      logic [35:0] m0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_valid", 64'(out_valid_n), 64'd0);
      check_eq("rst_result", 64'(res_n), 64'd0);
      check_eq("rst_flags", 64'(fl_n), 64'd0);
      check_eq("rst_in_ready", 64'(in_ready_n), 64'd1);
      @(posedge clk);
      #1;

      // Directed vectors with the output always ready
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      run_vec(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 32'h40400000, 4'b0000);
      run_vec(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 32'h3F800002, 4'b0001);
      run_vec(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 32'h7F7FFFFF, 4'b0101);
      run_vec(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 32'h00000000, 4'b0011);
      run_vec(32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000, 32'h7FC00000, 4'b1000);
      run_vec(32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000);
      run_vec(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 32'hFF800000, 4'b0000);
      run_vec(32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000, 32'hC0000000, 4'b0000);

      // Backpressure: five back-to-back ops against a stalled output
      drain();
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      acc_cnt   = 0;
      m0        = fp_mul_ref(bp_a[0], bp_b[0], 1'b1);
      fork
         begin
            for (int i = 0; i < 5; i++) send(bp_a[i], bp_b[i]);
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            @(negedge clk);
            check_eq("bp_accepted", 64'(acc_cnt), 64'd3);
            check_eq("bp_in_ready", 64'(in_ready_n), 64'd0);
            check_eq("bp_out_valid", 64'(out_valid_n), 64'd1);
            repeat (2) begin
               @(negedge clk);
               check_eq("bp_hold_res", 64'(res_n), 64'(m0[31:0]));
               check_eq("bp_hold_flags", 64'(fl_n), 64'(m0[35:32]));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check_eq("bp_total", 64'(acc_cnt), 64'd5);

      // Reset with two operations in flight
      lat_chk = 1'b1;
      send(32'h40400000, 32'h40400000);
      send(32'h3FC00000, 32'h3FC00000);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_eq("rst_mid_valid", 64'(out_valid_n), 64'd0);
      end
      @(posedge clk);
      #1;
      run_vec(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 32'h40C00000, 4'b0000);

      // Random operands with random bubbles and random backpressure
      lat_chk = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
               send(rand_op(), rand_op());
            end
            in_valid = 1'b0;
            rdone    = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
